// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and MEM-stage data
// access: one transaction at a time over a variable-latency valid/ready interface.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] ABORT_DATA  = 32'hDEADBEEF;
  localparam logic [3:0]        STREAK_MAX  = 4'(MAX_D_STREAK);
  localparam logic [8:0]        TIMER_LIMIT = 9'(TIMEOUT);

  state_t              state_r, state_s;
  logic [3:0]          streak_r, streak_s;
  logic [7:0]          timer_r, timer_s;
  logic [8:0]          timer_inc_s;
  logic                i_req_eff_s, d_req_eff_s;
  logic                mem_valid_r, mem_valid_s;
  logic                mem_we_r, mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
  logic [3:0]          mem_be_r, mem_be_s;
  logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
  logic                i_done_r, i_done_s;
  logic                d_done_r, d_done_s;
  logic [DATA_W-1:0]   i_rdata_r, i_rdata_s;
  logic [DATA_W-1:0]   d_rdata_r, d_rdata_s;
  logic                err_r, err_s;
  logic                unused_s;

  // Big-endian lane select: byte 0 of the word lives in mem_be[3].
  function automatic logic [3:0] lane_enable(input logic byte_access, input logic [1:0] offset);
    logic [3:0] be;
    if (byte_access) begin
      be = 4'b1000 >> offset;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  assign unused_s = ^i_addr[1:0];

  // Arbitration, transaction sequencing and timeout abort
  always_comb begin
    state_s     = state_r;
    streak_s    = streak_r;
    timer_s     = timer_r;
    mem_valid_s = mem_valid_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_be_s    = mem_be_r;
    mem_wdata_s = mem_wdata_r;
    i_done_s    = 1'b0;
    d_done_s    = 1'b0;
    i_rdata_s   = i_rdata_r;
    d_rdata_s   = d_rdata_r;
    err_s       = err_r;
    i_req_eff_s = i_req & ~i_done_r;
    d_req_eff_s = d_req & ~d_done_r;
    timer_inc_s = {1'b0, timer_r} + 9'd1;
    case (state_r)
      IDLE: begin
        // The done cycle is a settle cycle: requesters are still swapping req/addr.
        if ((i_done_r | d_done_r) == 1'b1) begin
          streak_s = i_req_eff_s ? streak_r : 4'd0;
        end else if (d_req_eff_s && ((streak_r < STREAK_MAX) || !i_req_eff_s)) begin
          state_s     = BUSY_D;
          timer_s     = 8'd0;
          mem_valid_s = 1'b1;
          mem_we_s    = d_we;
          mem_addr_s  = {d_addr[ADDR_W-1:2], 2'b00};
          mem_be_s    = lane_enable(d_byte, d_addr[1:0]);
          mem_wdata_s = d_byte ? {4{d_wdata[7:0]}} : d_wdata;
          streak_s    = i_req_eff_s ? (streak_r + 4'd1) : 4'd0;
        end else if (i_req_eff_s) begin
          state_s     = BUSY_I;
          timer_s     = 8'd0;
          mem_valid_s = 1'b1;
          mem_we_s    = 1'b0;
          mem_addr_s  = {i_addr[ADDR_W-1:2], 2'b00};
          mem_be_s    = 4'b1111;
          mem_wdata_s = {DATA_W{1'b0}};
          streak_s    = 4'd0;
        end else begin
          streak_s = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        // A ready arriving in the final allowed cycle completes normally.
        if (mem_ready) begin
          mem_valid_s = 1'b0;
          state_s     = IDLE;
          if (state_r == BUSY_I) begin
            i_done_s  = 1'b1;
            i_rdata_s = mem_rdata;
          end else begin
            d_done_s  = 1'b1;
            d_rdata_s = mem_we_r ? d_rdata_r : mem_rdata;
          end
        end else if (timer_inc_s == TIMER_LIMIT) begin
          mem_valid_s = 1'b0;
          state_s     = IDLE;
          err_s       = 1'b1;
          timer_s     = timer_inc_s[7:0];
          if (state_r == BUSY_I) begin
            i_done_s  = 1'b1;
            i_rdata_s = ABORT_DATA;
          end else begin
            d_done_s  = 1'b1;
            d_rdata_s = ABORT_DATA;
          end
        end else begin
          timer_s = timer_inc_s[7:0];
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      streak_r    <= 4'd0;
      timer_r     <= 8'd0;
      mem_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= {DATA_W{1'b0}};
      i_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
      i_rdata_r   <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      streak_r    <= streak_s;
      timer_r     <= timer_s;
      mem_valid_r <= mem_valid_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_be_r    <= mem_be_s;
      mem_wdata_r <= mem_wdata_s;
      i_done_r    <= i_done_s;
      d_done_r    <= d_done_s;
      i_rdata_r   <= i_rdata_s;
      d_rdata_r   <= d_rdata_s;
      err_r       <= err_s;
    end
  end

  assign i_done      = i_done_r;
  assign i_rdata     = i_rdata_r;
  assign d_done      = d_done_r;
  assign d_rdata     = d_rdata_r;
  assign mem_valid   = mem_valid_r;
  assign mem_we      = mem_we_r;
  assign mem_addr    = mem_addr_r;
  assign mem_be      = mem_be_r;
  assign mem_wdata   = mem_wdata_r;
  assign err_timeout = err_r;

endmodule
